// File: rtl/pci_target_mem.sv
// pci_target_mem
//   32-bit PCI memory target with a Type 0 configuration header, one memory
//   BAR and an internal dword RAM of 2**MEM_AW entries. Medium decode,
//   zero wait states, disconnect-with-data at the end of the BAR window and
//   on every configuration access. No fast back-to-back support.
//
// Ports
//   PCI_CLK   in     bus clock, rising-edge active
//   RESET     in     synchronous, active-high reset
//   IDSEL     in     configuration select (address phase)
//   FRAME_n   in     initiator frame
//   IRDY_n    in     initiator ready
//   C_BE      in     command (address phase) / active-low byte enables
//   AD        inout  address/data, driven only during read data phases
//   PAR       inout  even parity over AD and C_BE, one clock behind AD
//   DEVSEL_n  inout  device select (sustained tri-state)
//   TRDY_n    inout  target ready (sustained tri-state)
//   STOP_n    inout  target stop (sustained tri-state)
module pci_target_mem #(
    parameter logic [15:0] VENDOR_ID  = 16'h1AF4,
    parameter logic [15:0] DEVICE_ID  = 16'h0001,
    parameter logic [23:0] CLASS_CODE = 24'hFF0000,
    parameter int          MEM_AW     = 10
) (
    input  logic        PCI_CLK,
    input  logic        RESET,
    input  logic        IDSEL,
    input  logic        FRAME_n,
    input  logic        IRDY_n,
    input  logic [3:0]  C_BE,
    inout  wire  [31:0] AD,
    inout  wire         PAR,
    inout  wire         DEVSEL_n,
    inout  wire         TRDY_n,
    inout  wire         STOP_n
);
    localparam int BAR_LSB = MEM_AW + 2;

    typedef enum logic [2:0] {S_IDLE, S_DECODE, S_DATA, S_BACKOFF, S_BUSY} state_t;

    state_t              state_q, state_d;
    logic                frame_prev_q, frame_prev_d;
    logic                cfg_q, cfg_d;
    logic                write_q, write_d;
    logic [MEM_AW-1:0]   idx_q, idx_d;
    logic [5:0]          cfg_idx_q, cfg_idx_d;
    logic                stopped_q, stopped_d;
    logic                cmd_mem_q, cmd_mem_d;
    logic [31:BAR_LSB]   bar_q, bar_d;
    logic                par_q, par_d;
    logic                par_oe_q, par_oe_d;

    logic [31:0]         ram [2**MEM_AW];

    logic                addr_phase, mem_cmd, cfg_cmd, mem_hit, cfg_hit;
    logic                in_data, ctl_oe, trdy_int, stop_cond, xfer, ad_oe, ram_we;
    logic [31:0]         be_mask, bar_merge, cfg_rdata, rdata;

    // An address phase is the first clock of FRAME_n low seen from IDLE.
    assign addr_phase = (state_q == S_IDLE) && !FRAME_n && frame_prev_q;
    assign mem_cmd    = (C_BE == 4'h6) || (C_BE == 4'h7) || (C_BE == 4'hC) ||
                        (C_BE == 4'hE) || (C_BE == 4'hF);
    assign cfg_cmd    = (C_BE == 4'hA) || (C_BE == 4'hB);
    assign mem_hit    = mem_cmd && cmd_mem_q && (AD[31:BAR_LSB] == bar_q);
    assign cfg_hit    = cfg_cmd && IDSEL && (AD[1:0] == 2'b00) && (AD[10:8] == 3'b000);

    assign in_data    = (state_q == S_DATA);
    assign ctl_oe     = (state_q == S_DECODE) || in_data || (state_q == S_BACKOFF);
    assign trdy_int   = in_data && !stopped_q;
    // Config accesses are single-dword; memory bursts stop at the window end.
    assign stop_cond  = stopped_q || (cfg_q ? !FRAME_n : (&idx_q));
    assign xfer       = trdy_int && !IRDY_n;
    assign ad_oe      = in_data && !write_q;
    assign ram_we     = xfer && write_q && !cfg_q && !RESET;

    assign be_mask    = {{8{~C_BE[3]}}, {8{~C_BE[2]}}, {8{~C_BE[1]}}, {8{~C_BE[0]}}};
    assign bar_merge  = ({bar_q, {BAR_LSB{1'b0}}} & ~be_mask) | (AD & be_mask);

    always_comb begin
        cfg_rdata = 32'h0;
        case (cfg_idx_q)
            6'd0:    cfg_rdata = {DEVICE_ID, VENDOR_ID};
            6'd1:    cfg_rdata = {16'h0200, 14'h0, cmd_mem_q, 1'b0};
            6'd2:    cfg_rdata = {CLASS_CODE, 8'h00};
            6'd4:    cfg_rdata = {bar_q, {BAR_LSB{1'b0}}};
            default: cfg_rdata = 32'h0;
        endcase
    end

    assign rdata = cfg_q ? cfg_rdata : ram[idx_q];

    always_comb begin
        state_d      = state_q;
        frame_prev_d = FRAME_n;
        cfg_d        = cfg_q;
        write_d      = write_q;
        idx_d        = idx_q;
        cfg_idx_d    = cfg_idx_q;
        stopped_d    = stopped_q;
        cmd_mem_d    = cmd_mem_q;
        bar_d        = bar_q;
        par_d        = ^{rdata, C_BE};
        par_oe_d     = ad_oe;

        unique case (state_q)
            S_IDLE: begin
                if (addr_phase) begin
                    cfg_d     = cfg_hit;
                    write_d   = C_BE[0];
                    idx_d     = AD[BAR_LSB-1:2];
                    cfg_idx_d = AD[7:2];
                    state_d   = (mem_hit || cfg_hit) ? S_DECODE : S_BUSY;
                end
            end
            S_DECODE: begin
                stopped_d = 1'b0;
                state_d   = S_DATA;
            end
            S_DATA: begin
                if (xfer) begin
                    if (!cfg_q) begin
                        idx_d = idx_q + 1'b1;
                    end else if (write_q) begin
                        if (cfg_idx_q == 6'd1 && !C_BE[0]) begin
                            cmd_mem_d = AD[1];
                        end
                        if (cfg_idx_q == 6'd4) begin
                            bar_d = bar_merge[31:BAR_LSB];
                        end
                    end
                    if (FRAME_n) begin
                        state_d = S_BACKOFF;
                    end else if (stop_cond) begin
                        stopped_d = 1'b1;
                    end
                end else if (stopped_q && FRAME_n) begin
                    state_d = S_BACKOFF;
                end
            end
            S_BACKOFF: state_d = S_IDLE;
            S_BUSY: begin
                if (FRAME_n && IRDY_n) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge PCI_CLK) begin
        if (RESET) begin
            state_q      <= S_IDLE;
            frame_prev_q <= 1'b1;
            stopped_q    <= 1'b0;
            cmd_mem_q    <= 1'b0;
            bar_q        <= '0;
            par_oe_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_prev_q <= frame_prev_d;
            stopped_q    <= stopped_d;
            cmd_mem_q    <= cmd_mem_d;
            bar_q        <= bar_d;
            par_oe_q     <= par_oe_d;
        end
    end

    always_ff @(posedge PCI_CLK) begin
        cfg_q     <= cfg_d;
        write_q   <= write_d;
        idx_q     <= idx_d;
        cfg_idx_q <= cfg_idx_d;
        par_q     <= par_d;
    end

    // RAM contents survive reset.
    always_ff @(posedge PCI_CLK) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (!C_BE[b]) begin
                    ram[idx_q][8*b +: 8] <= AD[8*b +: 8];
                end
            end
        end
    end

    assign AD       = ad_oe    ? rdata                   : 'z;
    assign PAR      = par_oe_q ? par_q                   : 1'bz;
    assign DEVSEL_n = ctl_oe   ? !in_data                : 1'bz;
    assign TRDY_n   = ctl_oe   ? !trdy_int               : 1'bz;
    assign STOP_n   = ctl_oe   ? !(in_data && stop_cond) : 1'bz;

endmodule

// File: tb/tb_pci_target_mem.sv
// tb_pci_target_mem
//   Directed bench for pci_target_mem. Acts as a single PCI initiator with
//   zero-wait IRDY_n; the s/t/s lines and PAR carry pull-ups, so a released
//   line reads 1.
module tb_pci_target_mem;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, idsel, frame_n, irdy_n;
    logic [3:0]  c_be;
    logic [31:0] tb_ad;
    logic        tb_ad_oe;
    wire  [31:0] ad;
    wire         par, devsel_n, trdy_n, stop_n;

    assign ad = tb_ad_oe ? tb_ad : 'z;
    pullup (par);
    pullup (devsel_n);
    pullup (trdy_n);
    pullup (stop_n);

    pci_target_mem dut (
        .PCI_CLK  (clk),
        .RESET    (reset),
        .IDSEL    (idsel),
        .FRAME_n  (frame_n),
        .IRDY_n   (irdy_n),
        .C_BE     (c_be),
        .AD       (ad),
        .PAR      (par),
        .DEVSEL_n (devsel_n),
        .TRDY_n   (trdy_n),
        .STOP_n   (stop_n)
    );

    int          tests = 0;
    int          fails = 0;
    logic [31:0] wd [8];
    logic [3:0]  be [8];
    logic [31:0] ed [8];
    logic        es [8];

    function automatic logic par_of(input logic [31:0] d, input logic [3:0] b);
        return ^{d, b};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic bus_idle();
        frame_n  = 1'b1;
        irdy_n   = 1'b1;
        tb_ad_oe = 1'b0;
        tb_ad    = 32'h0;
        c_be     = 4'hF;
        idsel    = 1'b0;
    endtask

    task automatic clr();
        for (int k = 0; k < 8; k++) begin
            wd[k] = 32'h0;
            be[k] = 4'h0;
            ed[k] = 32'h0;
            es[k] = 1'b0;
        end
    endtask

    // One transaction: the initiator intends n data phases; es[] marks phases
    // where the target is expected to signal STOP_n, after which the
    // initiator deasserts FRAME_n and finishes.
    task automatic xact(input string tag, input logic [3:0] cmd, input logic [31:0] addr,
                        input logic sel, input int n, input logic hit);
        logic wr;
        logic fr;
        wr       = cmd[0];
        frame_n  = 1'b0;
        irdy_n   = 1'b1;
        tb_ad_oe = 1'b1;
        tb_ad    = addr;
        c_be     = cmd;
        idsel    = sel;
        tick();
        idsel    = 1'b0;
        irdy_n   = 1'b0;
        frame_n  = (n == 1);
        tb_ad_oe = wr;
        tb_ad    = wd[0];
        c_be     = be[0];
        smp();
        chk({tag, ":devsel_a1"}, 32'(devsel_n), 32'd1);
        tick();
        if (!hit) begin
            for (int k = 0; k < 3; k++) begin
                smp();
                chk({tag, ":devsel_miss"}, 32'(devsel_n), 32'd1);
                tick();
            end
            frame_n = 1'b1;
            tick();
            bus_idle();
            tick();
            tick();
            return;
        end
        for (int i = 0; i < n; i++) begin
            fr      = (i == n - 1);
            frame_n = fr;
            tb_ad   = wd[i];
            c_be    = be[i];
            smp();
            chk({tag, ":devsel"}, 32'(devsel_n), 32'd0);
            chk({tag, ":trdy"}, 32'(trdy_n), 32'd0);
            chk({tag, ":stop"}, 32'(stop_n), 32'(!es[i]));
            if (!wr) chk({tag, ":ad"}, ad, ed[i]);
            if (!wr && i > 0) chk({tag, ":par"}, 32'(par), 32'(par_of(ed[i-1], be[i-1])));
            tick();
            if (es[i] && !fr) begin
                frame_n  = 1'b1;
                tb_ad_oe = 1'b0;
                smp();
                chk({tag, ":trdy_stopped"}, 32'(trdy_n), 32'd1);
                chk({tag, ":stop_stopped"}, 32'(stop_n), 32'd0);
                if (!wr) chk({tag, ":par_stopped"}, 32'(par), 32'(par_of(ed[i], be[i])));
                tick();
                bus_idle();
                smp();
                chk({tag, ":devsel_backoff"}, 32'(devsel_n), 32'd1);
                tick();
                tick();
                return;
            end
        end
        bus_idle();
        smp();
        chk({tag, ":devsel_backoff"}, 32'(devsel_n), 32'd1);
        chk({tag, ":trdy_backoff"}, 32'(trdy_n), 32'd1);
        if (!wr) chk({tag, ":par_last"}, 32'(par), 32'(par_of(ed[n-1], be[n-1])));
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_idle();
        reset = 1'b1;
        tick();
        tick();
        tick();
        reset = 1'b0;
        smp();
        chk("rst:devsel", 32'(devsel_n), 32'd1);
        chk("rst:trdy", 32'(trdy_n), 32'd1);
        chk("rst:stop", 32'(stop_n), 32'd1);
        chk("rst:par", 32'(par), 32'd1);
        tick();

        // Config read of the ID dword; initiator wants two, target disconnects.
        clr(); ed[0] = 32'h0001_1AF4; es[0] = 1'b1;
        xact("cfg_id", 4'hA, 32'h0000_0000, 1'b1, 2, 1'b1);
        clr(); ed[0] = 32'hFF00_0000;
        xact("cfg_class", 4'hA, 32'h0000_0008, 1'b1, 1, 1'b1);
        clr(); ed[0] = 32'h0;
        xact("cfg_rsvd", 4'hA, 32'h0000_000C, 1'b1, 1, 1'b1);
        clr();
        xact("cfg_noidsel", 4'hA, 32'h0000_0000, 1'b0, 1, 1'b0);

        // BAR sizing and programming, command register.
        clr(); wd[0] = 32'hFFFF_FFFF;
        xact("bar_wr1", 4'hB, 32'h0000_0010, 1'b1, 1, 1'b1);
        clr(); ed[0] = 32'hFFFF_F000;
        xact("bar_size", 4'hA, 32'h0000_0010, 1'b1, 1, 1'b1);
        clr(); wd[0] = 32'h8000_0000;
        xact("bar_wr2", 4'hB, 32'h0000_0010, 1'b1, 1, 1'b1);
        clr(); wd[0] = 32'h0000_0002;
        xact("cmd_wr", 4'hB, 32'h0000_0004, 1'b1, 1, 1'b1);
        clr(); ed[0] = 32'h0200_0002;
        xact("cmd_rd", 4'hA, 32'h0000_0004, 1'b1, 1, 1'b1);

        // Four-dword burst write then read back.
        clr();
        for (int k = 0; k < 4; k++) wd[k] = 32'(k + 1);
        xact("mem_wr4", 4'h7, 32'h8000_0000, 1'b0, 4, 1'b1);
        clr();
        for (int k = 0; k < 4; k++) ed[k] = 32'(k + 1);
        xact("mem_rd4", 4'hC, 32'h8000_0000, 1'b0, 4, 1'b1);

        // Byte enables: 4'b0101 (active low) writes bytes 3 and 1 only.
        clr(); wd[0] = 32'h1122_3344;
        xact("be_base", 4'h7, 32'h8000_0010, 1'b0, 1, 1'b1);
        clr(); wd[0] = 32'hAABB_CCDD; be[0] = 4'b0101;
        xact("be_part", 4'h7, 32'h8000_0010, 1'b0, 1, 1'b1);
        clr(); ed[0] = 32'hAA22_CC44;
        xact("be_rd", 4'h6, 32'h8000_0010, 1'b0, 1, 1'b1);

        // Burst reaching the end of the window disconnects on the last dword.
        clr(); wd[0] = 32'h55; wd[1] = 32'h66; wd[2] = 32'h77; wd[3] = 32'h88; es[1] = 1'b1;
        xact("end_wr", 4'h7, 32'h8000_0FF8, 1'b0, 4, 1'b1);
        clr(); ed[0] = 32'h55; ed[1] = 32'h66; es[1] = 1'b1;
        xact("end_rd", 4'hE, 32'h8000_0FF8, 1'b0, 2, 1'b1);
        clr(); ed[0] = 32'h1;
        xact("nowrap_rd", 4'h6, 32'h8000_0000, 1'b0, 1, 1'b1);

        // Address outside the BAR window.
        clr();
        xact("miss", 4'h6, 32'h9000_0000, 1'b0, 1, 1'b0);

        // Reset in the middle of a read burst.
        frame_n  = 1'b0;
        irdy_n   = 1'b1;
        tb_ad_oe = 1'b1;
        tb_ad    = 32'h8000_0000;
        c_be     = 4'h6;
        tick();
        irdy_n   = 1'b0;
        tb_ad_oe = 1'b0;
        c_be     = 4'h0;
        tick();
        smp();
        chk("mrst:ad0", ad, 32'h1);
        tick();
        reset = 1'b1;
        smp();
        chk("mrst:ad1", ad, 32'h2);
        tick();
        reset = 1'b0;
        bus_idle();
        smp();
        chk("mrst:devsel", 32'(devsel_n), 32'd1);
        chk("mrst:trdy", 32'(trdy_n), 32'd1);
        chk("mrst:stop", 32'(stop_n), 32'd1);
        chk("mrst:par", 32'(par), 32'd1);
        tick();
        tick();

        clr(); ed[0] = 32'h0;
        xact("mrst_bar", 4'hA, 32'h0000_0010, 1'b1, 1, 1'b1);
        clr();
        xact("mrst_memoff", 4'h6, 32'h8000_0000, 1'b0, 1, 1'b0);
        clr(); wd[0] = 32'h8000_0000;
        xact("mrst_bar_wr", 4'hB, 32'h0000_0010, 1'b1, 1, 1'b1);
        clr(); wd[0] = 32'h0000_0002;
        xact("mrst_cmd_wr", 4'hB, 32'h0000_0004, 1'b1, 1, 1'b1);
        clr();
        for (int k = 0; k < 4; k++) ed[k] = 32'(k + 1);
        xact("mrst_rd4", 4'hC, 32'h8000_0000, 1'b0, 4, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
